// File: rtl/rpn_pkg.sv
// Shared opcode encodings and sizing helper for the RPN stack engine
// and the calculator controller.
package rpn_pkg;

   typedef enum logic [2:0] {
      OP_NOP    = 3'd0,
      OP_PUSH   = 3'd1,
      OP_POP    = 3'd2,
      OP_PEEK   = 3'd3,
      OP_DUP    = 3'd4,
      OP_SWAP   = 3'd5,
      OP_REDUCE = 3'd6,
      OP_CLEAR  = 3'd7
   } op_t;

   function automatic int clog2(input int value);
      int res;
      int v;
      res = 0;
      v   = value - 1;
      while (v > 0) begin
         res = res + 1;
         v   = v >> 1;
      end
      return res;
   endfunction

endpackage

// File: rtl/rpn_stack_regfile.sv
// Stack storage: two write ports and two combinational read ports (top, next).
// Contents are deliberately not reset.
module rpn_stack_regfile #(
   parameter int DATA_WIDTH = 4,
   parameter int DEPTH      = 8,
   parameter int AW         = 3
) (
   input  logic                  clk,
   input  logic                  we_a,
   input  logic [AW-1:0]         addr_a,
   input  logic [DATA_WIDTH-1:0] wdata_a,
   input  logic                  we_b,
   input  logic [AW-1:0]         addr_b,
   input  logic [DATA_WIDTH-1:0] wdata_b,
   input  logic [AW-1:0]         raddr_top,
   input  logic [AW-1:0]         raddr_next,
   output logic [DATA_WIDTH-1:0] rdata_top,
   output logic [DATA_WIDTH-1:0] rdata_next
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we_a) mem[addr_a] <= wdata_a;
      if (we_b) mem[addr_b] <= wdata_b;
   end

   assign rdata_top  = mem[raddr_top];
   assign rdata_next = mem[raddr_next];

endmodule

// File: rtl/rpn_stack_engine.sv
// LIFO operand stack for an RPN calculator: push/pop/peek/dup/swap/reduce/clear
// with sticky overflow/underflow error flag.
module rpn_stack_engine
   import rpn_pkg::*;
#(
   parameter int  DATA_WIDTH = 4,
   parameter int  DEPTH      = 8,
   localparam int CNT_WIDTH  = clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  op_valid,
   input  logic [2:0]            op,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] top,
   output logic [DATA_WIDTH-1:0] next,
   output logic [CNT_WIDTH-1:0]  count,
   output logic                  empty,
   output logic                  full,
   output logic                  err,
   input  logic                  err_clr
);

   localparam int AW = clog2(DEPTH);
   localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DEPTH);
   localparam logic [CNT_WIDTH-1:0] ONE_C    = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] TWO_C    = CNT_WIDTH'(2);
   localparam logic [AW-1:0]        ONE_A    = AW'(1);
   localparam logic [AW-1:0]        TWO_A    = AW'(2);

   logic [CNT_WIDTH-1:0]  cnt, cnt_nxt;
   logic [AW-1:0]         cnt_lo, tidx, nidx;
   logic [DATA_WIDTH-1:0] rd_top, rd_next;
   logic                  we_a, we_b, new_err, ld_out;
   logic [AW-1:0]         addr_a, addr_b;
   logic [DATA_WIDTH-1:0] wdata_a, wdata_b;

   // Address arithmetic is done modulo the array size; slots below zero are never used unmasked.
   assign cnt_lo = cnt[AW-1:0];
   assign tidx   = cnt_lo - ONE_A;
   assign nidx   = cnt_lo - TWO_A;

   rpn_stack_regfile #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .AW         (AW)
   ) u_regfile (
      .clk        (clk),
      .we_a       (we_a),
      .addr_a     (addr_a),
      .wdata_a    (wdata_a),
      .we_b       (we_b),
      .addr_b     (addr_b),
      .wdata_b    (wdata_b),
      .raddr_top  (tidx),
      .raddr_next (nidx),
      .rdata_top  (rd_top),
      .rdata_next (rd_next)
   );

   assign empty = (cnt == '0);
   assign full  = (cnt == FULL_CNT);
   assign count = cnt;
   assign top   = (cnt >= ONE_C) ? rd_top  : '0;
   assign next  = (cnt >= TWO_C) ? rd_next : '0;

   always_comb begin
      cnt_nxt = cnt;
      we_a    = 1'b0;
      we_b    = 1'b0;
      addr_a  = cnt_lo;
      addr_b  = nidx;
      wdata_a = data_in;
      wdata_b = rd_top;
      new_err = 1'b0;
      ld_out  = 1'b0;
      if (op_valid) begin
         case (op_t'(op))
            OP_PUSH: begin
               if (full) new_err = 1'b1;
               else begin
                  we_a    = 1'b1;
                  cnt_nxt = cnt + ONE_C;
               end
            end
            OP_POP: begin
               if (empty) new_err = 1'b1;
               else begin
                  ld_out  = 1'b1;
                  cnt_nxt = cnt - ONE_C;
               end
            end
            OP_PEEK: begin
               if (empty) new_err = 1'b1;
               else ld_out = 1'b1;
            end
            OP_DUP: begin
               if (full || empty) new_err = 1'b1;
               else begin
                  we_a    = 1'b1;
                  wdata_a = rd_top;
                  cnt_nxt = cnt + ONE_C;
               end
            end
            OP_SWAP: begin
               if (cnt < TWO_C) new_err = 1'b1;
               else begin
                  we_a    = 1'b1;
                  addr_a  = tidx;
                  wdata_a = rd_next;
                  we_b    = 1'b1;
               end
            end
            OP_REDUCE: begin
               if (cnt < TWO_C) new_err = 1'b1;
               else begin
                  we_a    = 1'b1;
                  addr_a  = nidx;
                  cnt_nxt = cnt - ONE_C;
               end
            end
            OP_CLEAR: cnt_nxt = '0;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         data_out  <= '0;
         out_valid <= 1'b0;
         err       <= 1'b0;
      end else begin
         cnt       <= cnt_nxt;
         out_valid <= ld_out;
         if (ld_out) data_out <= rd_top;
         if (new_err)      err <= 1'b1;
         else if (err_clr) err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rpn_stack_engine.sv
// Self-checking bench for rpn_stack_engine: directed scenarios plus a randomized
// run against a queue-based stack model.
module tb_rpn_stack_engine;

   localparam int DW = 4;
   localparam int DP = 8;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          op_valid = 1'b0;
   logic [2:0]    op = 3'd0;
   logic [DW-1:0] data_in = '0;
   logic          err_clr = 1'b0;
   logic [DW-1:0] data_out, top, next;
   logic          out_valid, empty, full, err;
   logic [CW-1:0] count;

   int checks = 0;
   int failures = 0;

   // Reference model: stack as a queue, back = top.
   int m_q[$];
   bit m_err;
   int m_dout;
   bit m_ovld;

   always #5 clk = ~clk;

   rpn_stack_engine #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
      .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op(op), .data_in(data_in),
      .data_out(data_out), .out_valid(out_valid), .top(top), .next(next),
      .count(count), .empty(empty), .full(full), .err(err), .err_clr(err_clr)
   );

   function automatic int m_top();
      return (m_q.size() >= 1) ? m_q[m_q.size()-1] : 0;
   endfunction

   function automatic int m_next();
      return (m_q.size() >= 2) ? m_q[m_q.size()-2] : 0;
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_err  = 0;
      m_dout = 0;
      m_ovld = 0;
   endtask

   task automatic model_step(input bit v, input int o, input int d, input bit c);
      bit bad;
      int a, b;
      bad    = 0;
      m_ovld = 0;
      if (v) begin
         case (o)
            1: if (m_q.size() == DP) bad = 1; else m_q.push_back(d);
            2: if (m_q.size() == 0) bad = 1;
               else begin m_dout = m_q.pop_back(); m_ovld = 1; end
            3: if (m_q.size() == 0) bad = 1;
               else begin m_dout = m_top(); m_ovld = 1; end
            4: if (m_q.size() == 0 || m_q.size() == DP) bad = 1; else m_q.push_back(m_top());
            5: if (m_q.size() < 2) bad = 1;
               else begin
                  a = m_q.pop_back(); b = m_q.pop_back();
                  m_q.push_back(a); m_q.push_back(b);
               end
            6: if (m_q.size() < 2) bad = 1;
               else begin
                  a = m_q.pop_back(); b = m_q.pop_back();
                  m_q.push_back(d);
               end
            7: m_q.delete();
            default: ;
         endcase
      end
      if (bad) m_err = 1;
      else if (c) m_err = 0;
   endtask

   // Drive one cycle of stimulus; outputs are sampled 1 time unit after the edge.
   task automatic step(input bit v, input int o, input int d, input bit c);
      op_valid = v;
      op       = 3'(o);
      data_in  = DW'(d);
      err_clr  = c;
      @(posedge clk);
      #1;
      model_step(v, o, d, c);
      op_valid = 1'b0;
      err_clr  = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      model_reset();
      #12;
      checks++; if (count !== 4'd0)   begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
      checks++; if (empty !== 1'b1)   begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
      checks++; if (full !== 1'b0)    begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
      checks++; if (err !== 1'b0)     begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_ovld got=%b exp=0", out_valid); end
      checks++; if (data_out !== 4'd0 || top !== 4'd0 || next !== 4'd0)
         begin failures++; $display("FAIL reset_data got dout=%0d top=%0d next=%0d exp=0", data_out, top, next); end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_push_pop();
      step(1, 7, 0, 1);
      step(1, 1, 3, 0);
      step(1, 1, 5, 0);
      step(1, 1, 9, 0);
      checks++; if (count !== 4'd3 || top !== 4'd9 || next !== 4'd5)
         begin failures++; $display("FAIL push3 got count=%0d top=%0d next=%0d exp 3/9/5", count, top, next); end
      step(1, 2, 0, 0);
      checks++; if (data_out !== 4'd9 || out_valid !== 1'b1 || count !== 4'd2)
         begin failures++; $display("FAIL pop got dout=%0d ovld=%b count=%0d exp 9/1/2", data_out, out_valid, count); end
      step(0, 0, 0, 0);
      checks++; if (out_valid !== 1'b0 || data_out !== 4'd9)
         begin failures++; $display("FAIL pop_pulse got ovld=%b dout=%0d exp 0/9", out_valid, data_out); end
   endtask

   task automatic test_overflow();
      step(1, 7, 0, 1);
      for (int i = 0; i < DP; i++) step(1, 1, i + 2, 0);
      checks++; if (full !== 1'b1 || count !== 4'd8 || err !== 1'b0)
         begin failures++; $display("FAIL fill got full=%b count=%0d err=%b exp 1/8/0", full, count, err); end
      step(1, 1, 1, 0);
      checks++; if (full !== 1'b1 || err !== 1'b1 || count !== 4'd8 || top !== 4'd9 || next !== 4'd8)
         begin failures++; $display("FAIL overflow got full=%b err=%b count=%0d top=%0d next=%0d exp 1/1/8/9/8",
                                    full, err, count, top, next); end
      step(1, 4, 0, 0);
      checks++; if (count !== 4'd8 || top !== 4'd9)
         begin failures++; $display("FAIL dup_full got count=%0d top=%0d exp 8/9", count, top); end
   endtask

   task automatic test_swap_reduce();
      step(1, 7, 0, 1);
      step(1, 1, 2, 0);
      step(1, 1, 7, 0);
      step(1, 5, 0, 0);
      checks++; if (top !== 4'd2 || next !== 4'd7 || count !== 4'd2)
         begin failures++; $display("FAIL swap got top=%0d next=%0d count=%0d exp 2/7/2", top, next, count); end
      step(1, 6, 9, 0);
      checks++; if (count !== 4'd1 || top !== 4'd9 || next !== 4'd0)
         begin failures++; $display("FAIL reduce got count=%0d top=%0d next=%0d exp 1/9/0", count, top, next); end
      step(1, 5, 0, 0);
      checks++; if (err !== 1'b1 || count !== 4'd1 || top !== 4'd9)
         begin failures++; $display("FAIL swap_under got err=%b count=%0d top=%0d exp 1/1/9", err, count, top); end
      step(1, 6, 3, 1);
      checks++; if (err !== 1'b1 || count !== 4'd1 || top !== 4'd9)
         begin failures++; $display("FAIL reduce_under got err=%b count=%0d top=%0d exp 1/1/9", err, count, top); end
   endtask

   task automatic test_underflow_err();
      step(1, 7, 0, 1);
      checks++; if (empty !== 1'b1 || err !== 1'b0)
         begin failures++; $display("FAIL clear_errclr got empty=%b err=%b exp 1/0", empty, err); end
      step(1, 2, 0, 0);
      checks++; if (err !== 1'b1 || out_valid !== 1'b0 || count !== 4'd0)
         begin failures++; $display("FAIL pop_empty got err=%b ovld=%b count=%0d exp 1/0/0", err, out_valid, count); end
      step(1, 3, 0, 1);
      checks++; if (err !== 1'b1 || out_valid !== 1'b0)
         begin failures++; $display("FAIL err_priority got err=%b ovld=%b exp 1/0", err, out_valid); end
      step(0, 0, 0, 1);
      checks++; if (err !== 1'b0)
         begin failures++; $display("FAIL err_clr got err=%b exp 0", err); end
   endtask

   task automatic test_dup_peek_clear();
      step(1, 1, 4, 0);
      step(1, 4, 0, 0);
      checks++; if (count !== 4'd2 || top !== 4'd4 || next !== 4'd4)
         begin failures++; $display("FAIL dup got count=%0d top=%0d next=%0d exp 2/4/4", count, top, next); end
      step(1, 3, 0, 0);
      checks++; if (data_out !== 4'd4 || out_valid !== 1'b1 || count !== 4'd2)
         begin failures++; $display("FAIL peek got dout=%0d ovld=%b count=%0d exp 4/1/2", data_out, out_valid, count); end
      step(1, 1, 15, 0);
      step(1, 7, 0, 0);
      checks++; if (empty !== 1'b1 || count !== 4'd0 || top !== 4'd0 || err !== 1'b0)
         begin failures++; $display("FAIL clear got empty=%b count=%0d top=%0d err=%b exp 1/0/0/0", empty, count, top, err); end
   endtask

   task automatic test_async_reset();
      step(1, 1, 6, 0);
      step(1, 1, 11, 0);
      step(1, 2, 0, 0);
      step(1, 2, 0, 0);
      // A bad op sets err so the reset's effect on it is observable too.
      step(1, 2, 0, 0);
      op_valid = 1'b1; op = 3'd1; data_in = 4'd3;
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (count !== 4'd0 || out_valid !== 1'b0 || err !== 1'b0 || data_out !== 4'd0)
         begin failures++; $display("FAIL async_reset got count=%0d ovld=%b err=%b dout=%0d exp 0/0/0/0",
                                    count, out_valid, err, data_out); end
      @(posedge clk);
      #1;
      checks++; if (count !== 4'd0 || empty !== 1'b1)
         begin failures++; $display("FAIL reset_held got count=%0d empty=%b exp 0/1", count, empty); end
      op_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      step(1, 2, 0, 0);
      checks++; if (err !== 1'b1 || out_valid !== 1'b0 || count !== 4'd0)
         begin failures++; $display("FAIL post_reset got err=%b ovld=%b count=%0d exp 1/0/0", err, out_valid, count); end
   endtask

   task automatic test_random();
      int o, d;
      bit v, c;
      for (int n = 0; n < 400; n++) begin
         v = ($urandom_range(0, 9) != 0);
         o = (($urandom_range(0, 3) == 0)) ? 1 : $urandom_range(0, 7);
         if (o == 7 && $urandom_range(0, 2) != 0) o = 1;
         d = $urandom_range(0, 15);
         c = ($urandom_range(0, 5) == 0);
         step(v, o, d, c);
         checks++; if (count !== CW'(m_q.size()))
            begin failures++; $display("FAIL rnd_count n=%0d got=%0d exp=%0d", n, count, m_q.size()); end
         checks++; if (top !== DW'(m_top()) || next !== DW'(m_next()))
            begin failures++; $display("FAIL rnd_topnext n=%0d got=%0d/%0d exp=%0d/%0d", n, top, next, m_top(), m_next()); end
         checks++; if (out_valid !== m_ovld || data_out !== DW'(m_dout))
            begin failures++; $display("FAIL rnd_out n=%0d got=%b/%0d exp=%b/%0d", n, out_valid, data_out, m_ovld, m_dout); end
         checks++; if (err !== m_err)
            begin failures++; $display("FAIL rnd_err n=%0d got=%b exp=%b", n, err, m_err); end
         checks++; if (empty !== (m_q.size() == 0) || full !== (m_q.size() == DP))
            begin failures++; $display("FAIL rnd_flags n=%0d got=%b/%b size=%0d", n, empty, full, m_q.size()); end
      end
   endtask

   initial begin
      test_reset();
      test_push_pop();
      test_overflow();
      test_swap_reduce();
      test_underflow_err();
      test_dup_peek_clear();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
